// File: rtl/mw_arith_pkg.sv
// mw_arith_pkg: shared limb width, FSM state type and index-width helper for multi-word arithmetic
package mw_arith_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mw_state_t;

    // Width of a limb index; a single-limb design still needs one bit.
    function automatic int idx_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/cla16.sv
// cla16: 16-bit carry-lookahead adder built from four 4-bit lookahead groups
//   a, b  : addends
//   cin   : carry in
//   s     : sum
//   cout  : carry out
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [16:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;

    // Group generate/propagate give each group's carry-out directly from the
    // group carry-in; only the three inner carries of a group ripple.
    always_comb begin
        w_g    = a & b;
        w_p    = a ^ b;
        w_gg   = '0;
        w_gp   = '0;
        w_c    = '0;
        w_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | ((&w_p[4*k+2 +: 2]) & w_g[4*k+1])
                    | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
            for (int i = 0; i < 3; i++)
                w_c[4*k+i+1] = w_g[4*k+i] | (w_p[4*k+i] & w_c[4*k+i]);
            w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
        end
    end

    assign s    = w_p ^ w_c[15:0];
    assign cout = w_c[16];

endmodule

// File: rtl/sub_limb16.sv
// sub_limb16: one 16-bit limb of a subtraction, d = a - b - borrowIn, on a cla16
//   a, b      : minuend / subtrahend limb
//   borrowIn  : borrow from the lower limb
//   d         : difference limb
//   borrowOut : borrow into the next limb
module sub_limb16 (
    output logic [15:0] d,
    output logic        borrowOut,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        borrowIn
);

    logic w_cout;

    // a - b - bin == a + ~b + ~bin; the adder's carry is the inverted borrow.
    cla16 u_cla (
        .a    (a),
        .b    (~b),
        .cin  (~borrowIn),
        .s    (d),
        .cout (w_cout)
    );

    assign borrowOut = ~w_cout;

endmodule

// File: rtl/mw_sub_seq.sv
// mw_sub_seq: sequential multi-word subtractor d = a - b - bIn, one 16-bit limb per cycle
//   clk, resetN        : clock, synchronous active-low reset
//   inValid / inReady  : request handshake (inReady high only in IDLE)
//   a, b, bIn          : minuend, subtrahend, borrow-in (sampled at accept)
//   outValid / outReady: result handshake (outValid high only in DONE)
//   d                  : difference mod 2^(16*WORDS)
//   bOut, zero, v      : final borrow, d==0, signed overflow
module mw_sub_seq
    import mw_arith_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    input  logic                    bIn,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [LIMB_W*WORDS-1:0] d,
    output logic                    bOut,
    output logic                    zero,
    output logic                    v
);

    localparam int W  = LIMB_W * WORDS;
    localparam int IW = idx_w(WORDS);

    mw_state_t         r_state;
    mw_state_t         w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_d;
    logic [IW-1:0]     r_idx;
    logic              r_borrow;
    logic              r_bout;
    logic              r_zero;
    logic              r_v;
    logic [LIMB_W-1:0] w_d_limb;
    logic              w_borrow_out;
    logic [W-1:0]      w_d_full;
    logic              w_accept;
    logic              w_last;

    sub_limb16 u_limb (
        .d         (w_d_limb),
        .borrowOut (w_borrow_out),
        .a         (r_a[r_idx*LIMB_W +: LIMB_W]),
        .b         (r_b[r_idx*LIMB_W +: LIMB_W]),
        .borrowIn  (r_borrow)
    );

    assign w_accept = inValid && inReady;
    assign w_last   = (r_idx == IW'(WORDS - 1));

    // Final difference with the limb being produced this cycle merged in, so
    // the flags see the complete result on the last limb's edge.
    always_comb begin
        w_d_full = r_d;
        w_d_full[r_idx*LIMB_W +: LIMB_W] = w_d_limb;
    end

    always_comb begin
        w_next   = r_state;
        inReady  = (r_state == IDLE);
        outValid = (r_state == DONE);
        case (r_state)
            IDLE:    w_next = inValid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = outReady ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_borrow <= bIn;
                r_idx    <= '0;
                r_d      <= '0;
                r_bout   <= 1'b0;
                r_zero   <= 1'b0;
                r_v      <= 1'b0;
            end else if (r_state == RUN) begin
                r_d[r_idx*LIMB_W +: LIMB_W] <= w_d_limb;
                r_borrow <= w_borrow_out;
                r_idx    <= r_idx + 1'b1;
                if (w_last) begin
                    r_bout <= w_borrow_out;
                    r_zero <= (w_d_full == '0);
                    r_v    <= (r_a[W-1] != r_b[W-1]) && (w_d_full[W-1] != r_a[W-1]);
                end
            end
        end
    end

    assign d    = r_d;
    assign bOut = r_bout;
    assign zero = r_zero;
    assign v    = r_v;

endmodule
